bus_oe_arbiter: RTL

- Arbitrates N requesters sharing one pulled-up tri-state memory data bus.
- Each requester drives the bus through its own dual 4-bit buffer bank.
- Generates active-low output enables with a settle interval after turn-on and dead-time after turn-off, so no two banks ever drive the bus together.
- Sits between the memory sequencing logic (requesters) and the buffer banks' OE_ pins.

---
 rtl/bus_oe_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/bus_oe_arbiter.sv
// Round-robin output-enable arbiter for N buffer banks on one shared,
// pulled-up tri-state data bus. A bank is enabled, allowed to settle, held
// while its requester wants the bus, and then released. Every bank stays off
// for a dead-time between grants, so two banks never drive the bus together.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | bus released; arbitrate among REQ at the next edge
// SETTLE | OE_ of the owner low, waiting SETTLE cycles before VALID
// HOLD   | owner drives a settled bus; VALID high; hold counter running
// DEAD   | all OE_ high for DEAD cycles; REQ ignored
module bus_oe_arbiter #(
   parameter int N        = 4,
   parameter int SETTLE   = 1,
   parameter int DEAD     = 2,
   parameter int MAX_HOLD = 16
) (
   input  logic                 CLK,
   input  logic                 RST_,
   input  logic [N-1:0]         REQ,
   output logic [N-1:0]         GNT,
   output logic [N-1:0]         OE_,
   output logic                 VALID,
   output logic [$clog2(N)-1:0] OWNER,
   output logic                 BUSY
);

   localparam int IW = $clog2(N);
   localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;
   localparam logic [1:0] ST_DEAD   = 2'd3;

   localparam logic [N-1:0]  ONE_HOT0   = N'(1);
   localparam logic [IW:0]   N_W        = (IW + 1)'(N);
   localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
   localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
   // First HOLD cycle counts as one; with preemption disabled the counter stays at zero.
   localparam logic [HW-1:0] HOLD_FIRST = HW'((MAX_HOLD > 0) ? 1 : 0);
   localparam logic [3:0]    SETTLE_TC  = 4'(SETTLE - 1);
   localparam logic [3:0]    DEAD_TC    = 4'(DEAD - 1);

   logic [1:0]    state;
   logic [IW-1:0] ptr;
   logic [3:0]    tmr;
   logic [HW-1:0] hold_cnt;

   logic [IW-1:0] pick;
   logic          pick_ok;
   logic [IW:0]   sum;
   logic [IW-1:0] idx;
   logic          others_waiting;
   logic          owner_req;
   logic          preempt;
   logic          release_now;

   // OE_ is the exact complement of the registered grant vector
   assign OE_ = ~GNT;

   // first requester at or after the round-robin pointer; lowest offset wins
   always_comb begin
      pick    = '0;
      pick_ok = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int i = N - 1; i >= 0; i--) begin
         sum = {1'b0, ptr} + (IW + 1)'(i);
         if (sum >= N_W) begin
            sum = sum - N_W;
         end
         idx = sum[IW-1:0];
         if (REQ[idx]) begin
            pick    = idx;
            pick_ok = 1'b1;
         end
      end
   end

   // release on owner drop (SETTLE or HOLD) or on preemption after MAX_HOLD cycles
   always_comb begin
      others_waiting = |(REQ & ~GNT);
      owner_req      = REQ[OWNER];
      preempt        = (MAX_HOLD > 0) && (hold_cnt == HOLD_LIMIT) && others_waiting;
      release_now    = ((state == ST_SETTLE) && !owner_req) ||
                       ((state == ST_HOLD) && (!owner_req || preempt));
   end

   // sequencing FSM with registered outputs
   always_ff @(posedge CLK) begin
      if (!RST_) begin
         state    <= ST_IDLE;
         GNT      <= '0;
         VALID    <= 1'b0;
         BUSY     <= 1'b0;
         OWNER    <= '0;
         ptr      <= '0;
         tmr      <= '0;
         hold_cnt <= '0;
      end else if (release_now) begin
         state    <= ST_DEAD;
         GNT      <= '0;
         VALID    <= 1'b0;
         ptr      <= (OWNER == LAST_IDX) ? '0 : OWNER + 1'b1;
         tmr      <= DEAD_TC;
         hold_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_ok) begin
                  GNT   <= ONE_HOT0 << pick;
                  OWNER <= pick;
                  BUSY  <= 1'b1;
                  if (SETTLE == 0) begin
                     state    <= ST_HOLD;
                     VALID    <= 1'b1;
                     hold_cnt <= HOLD_FIRST;
                  end else begin
                     state <= ST_SETTLE;
                     tmr   <= SETTLE_TC;
                  end
               end
            end
            ST_SETTLE: begin
               if (tmr == 4'd0) begin
                  state    <= ST_HOLD;
                  VALID    <= 1'b1;
                  hold_cnt <= HOLD_FIRST;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            ST_HOLD: begin
               if (hold_cnt != HOLD_LIMIT) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            ST_DEAD: begin
               if (tmr == 4'd0) begin
                  state <= ST_IDLE;
                  BUSY  <= 1'b0;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
